// File: rtl/keccak_f_engine.sv
// keccak_f_engine: iterative Keccak-f[25*LANE_W] permutation with valid/ready
// on both sides. ROUNDS_PER_CYCLE rounds are unrolled per clock and the
// round sequencing / round constants are generated internally.
// Optional feature macro: KECCAK_NROUNDS_PORT_EN adds the in_rounds port so a
// caller can request only the last in_rounds rounds (TurboSHAKE/K12 style).
module keccak_f_engine #(
    parameter int LANE_W           = 64,
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [25*LANE_W-1:0]  in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [25*LANE_W-1:0]  out_data,
    output logic                  busy,
    output logic [4:0]            round_idx
`ifdef KECCAK_NROUNDS_PORT_EN
    ,
    input  logic [4:0]            in_rounds
`endif
);
    localparam int B  = 25 * LANE_W;
    localparam int L  = $clog2(LANE_W);
    localparam int NR = 12 + 2 * L;
    localparam int R  = ROUNDS_PER_CYCLE;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef logic [LANE_W-1:0] lane_t;

    if (!(LANE_W == 8 || LANE_W == 16 || LANE_W == 32 || LANE_W == 64)) begin : g_bad_lane
        $error("keccak_f_engine: LANE_W must be 8, 16, 32 or 64");
    end
    if (R < 1 || (NR % ((R < 1) ? 1 : R)) != 0) begin : g_bad_rpc
        $error("keccak_f_engine: ROUNDS_PER_CYCLE must divide the round count");
    end

    // Compressed round constants: bit j lands on lane bit 2^j-1.
    function automatic logic [6:0] rc7(input logic [4:0] idx);
        case (idx)
            5'd0:  rc7 = 7'h01;  5'd1:  rc7 = 7'h1A;  5'd2:  rc7 = 7'h5E;  5'd3:  rc7 = 7'h70;
            5'd4:  rc7 = 7'h1F;  5'd5:  rc7 = 7'h21;  5'd6:  rc7 = 7'h79;  5'd7:  rc7 = 7'h55;
            5'd8:  rc7 = 7'h0E;  5'd9:  rc7 = 7'h0C;  5'd10: rc7 = 7'h35;  5'd11: rc7 = 7'h26;
            5'd12: rc7 = 7'h3F;  5'd13: rc7 = 7'h4F;  5'd14: rc7 = 7'h5D;  5'd15: rc7 = 7'h53;
            5'd16: rc7 = 7'h52;  5'd17: rc7 = 7'h48;  5'd18: rc7 = 7'h16;  5'd19: rc7 = 7'h66;
            5'd20: rc7 = 7'h79;  5'd21: rc7 = 7'h58;  5'd22: rc7 = 7'h21;  5'd23: rc7 = 7'h74;
            default: rc7 = 7'h00;
        endcase
    endfunction

    // 64-bit rho offsets indexed by lane 5y+x; reduced mod LANE_W at use.
    function automatic int rho_off(input int i);
        case (i)
            0:  rho_off = 0;   1:  rho_off = 1;   2:  rho_off = 62;  3:  rho_off = 28;  4:  rho_off = 27;
            5:  rho_off = 36;  6:  rho_off = 44;  7:  rho_off = 6;   8:  rho_off = 55;  9:  rho_off = 20;
            10: rho_off = 3;   11: rho_off = 10;  12: rho_off = 43;  13: rho_off = 25;  14: rho_off = 39;
            15: rho_off = 41;  16: rho_off = 45;  17: rho_off = 15;  18: rho_off = 21;  19: rho_off = 8;
            20: rho_off = 18;  21: rho_off = 2;   22: rho_off = 61;  23: rho_off = 56;  24: rho_off = 14;
            default: rho_off = 0;
        endcase
    endfunction

    function automatic lane_t rotl(input lane_t v, input int n);
        return (n == 0) ? v : ((v << n) | (v >> (LANE_W - n)));
    endfunction

    // One full round (theta, rho, pi, chi, iota) on a packed state.
    function automatic logic [B-1:0] keccak_round(input logic [B-1:0] s, input logic [6:0] rc);
        lane_t       a [25];
        lane_t       b [25];
        lane_t       c [5];
        lane_t       d [5];
        logic [63:0] rcw;
        logic [B-1:0] r;
        for (int i = 0; i < 25; i++) a[i] = s[B-1-LANE_W*i -: LANE_W];
        for (int x = 0; x < 5; x++) c[x] = a[x] ^ a[x+5] ^ a[x+10] ^ a[x+15] ^ a[x+20];
        for (int x = 0; x < 5; x++) d[x] = c[(x+4)%5] ^ rotl(c[(x+1)%5], 1);
        for (int i = 0; i < 25; i++) a[i] = a[i] ^ d[i%5];
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                b[y + 5*((2*x + 3*y) % 5)] = rotl(a[x+5*y], rho_off(x+5*y) % LANE_W);
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                a[x+5*y] = b[x+5*y] ^ (~b[(x+1)%5 + 5*y] & b[(x+2)%5 + 5*y]);
        rcw = '0;
        rcw[0]  = rc[0];  rcw[1]  = rc[1];  rcw[3]  = rc[2];  rcw[7] = rc[3];
        rcw[15] = rc[4];  rcw[31] = rc[5];  rcw[63] = rc[6];
        a[0] = a[0] ^ lane_t'(rcw);
        r = '0;
        for (int i = 0; i < 25; i++) r[B-1-LANE_W*i -: LANE_W] = a[i];
        return r;
    endfunction

    logic [1:0]   fsm_q, fsm_d;
    logic [B-1:0] state_q, state_d;
    logic [4:0]   round_q, round_d;
    logic [B-1:0] run_state;
    logic [4:0]   first_round;
    logic         accept;

    assign in_ready  = (fsm_q == ST_IDLE) | ((fsm_q == ST_DONE) & out_ready);
    assign out_valid = (fsm_q == ST_DONE);
    assign busy      = (fsm_q == ST_RUN);
    assign out_data  = state_q;
    assign round_idx = round_q;
    assign accept    = in_valid & in_ready;

    // Starting round index for a newly accepted state.
    always_comb begin
        first_round = 5'd0;
`ifdef KECCAK_NROUNDS_PORT_EN
        if (in_rounds != 5'd0 && in_rounds <= 5'(NR) && (in_rounds % 5'(R)) == 5'd0)
            first_round = 5'(NR) - in_rounds;
`endif
    end

    // ROUNDS_PER_CYCLE unrolled rounds starting at the current round index.
    always_comb begin
        run_state = state_q;
        for (int k = 0; k < R; k++)
            run_state = keccak_round(run_state, rc7(round_q + 5'(k)));
    end

    // Next-state logic: round sequencing and handshakes.
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        round_d = round_q;
        case (fsm_q)
            ST_RUN: begin
                state_d = run_state;
                round_d = round_q + 5'(R);
                if (round_q + 5'(R) == 5'(NR)) fsm_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    fsm_d   = ST_IDLE;
                    round_d = 5'd0;
                end
            end
            default: ;
        endcase
        // A new accept (from IDLE or the overlapping DONE cycle) wins.
        if (accept) begin
            state_d = in_data;
            round_d = first_round;
            fsm_d   = ST_RUN;
        end
    end

    // State, round index and FSM registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= ST_IDLE;
            state_q <= '0;
            round_q <= 5'd0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            round_q <= round_d;
        end
    end
endmodule

// File: tb/tb_keccak_f_engine.sv
// Testbench for keccak_f_engine: known-answer table, backpressure, reset,
// and random states at every lane width against a spec-level Keccak model.
module tb_keccak_f_engine;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          in_valid, in_ready, out_valid, out_ready, busy;
    logic [1599:0] in_data, out_data;
    logic [4:0]    round_idx;
`ifdef KECCAK_NROUNDS_PORT_EN
    logic [4:0]    in_rounds;
    logic [4:0]    sub_rounds;
`endif

    int checks = 0;
    int errors = 0;

    keccak_f_engine #(.LANE_W(64), .ROUNDS_PER_CYCLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy), .round_idx(round_idx)
`ifdef KECCAK_NROUNDS_PORT_EN
        , .in_rounds(in_rounds)
`endif
    );

    // Secondary engines: (8,R3) (16,R2) (32,R11) (64,R24).
    logic [3:0]         s_ivld, s_ordy, s_irdy, s_ovld, s_busy;
    logic [3:0][1599:0] s_din, s_dout;
    logic [3:0][4:0]    s_ridx;

    for (genvar g = 0; g < 4; g++) begin : g_cfg
        localparam int W   = 8 << g;
        localparam int RPC = (g == 0) ? 3 : (g == 1) ? 2 : (g == 2) ? 11 : 24;
        logic [25*W-1:0] dout;
        keccak_f_engine #(.LANE_W(W), .ROUNDS_PER_CYCLE(RPC)) u_dut (
            .clk(clk), .rst_n(rst_n), .in_valid(s_ivld[g]), .in_ready(s_irdy[g]),
            .in_data(s_din[g][25*W-1:0]), .out_valid(s_ovld[g]), .out_ready(s_ordy[g]),
            .out_data(dout), .busy(s_busy[g]), .round_idx(s_ridx[g])
`ifdef KECCAK_NROUNDS_PORT_EN
            , .in_rounds(sub_rounds)
`endif
        );
        if (W < 64) begin : g_pad
            assign s_dout[g][1599:25*W] = '0;
        end
        assign s_dout[g][25*W-1:0] = dout;
    end

    // ---------------- reference model ----------------
    function automatic int rpc_of(input int g);
        return (g == 0) ? 3 : (g == 1) ? 2 : (g == 2) ? 11 : 24;
    endfunction

    function automatic int nr_of(input int w);
        return 12 + 2 * $clog2(w);
    endfunction

    // rc(t) from the 8-bit LFSR x^8+x^6+x^5+x^4+1.
    function automatic logic lfsr_rc(input int t);
        int r;
        r = 1;
        for (int i = 1; i <= t % 255; i++) begin
            r = r << 1;
            if ((r & 256) != 0) r = r ^ 256 ^ 1 ^ 16 ^ 32 ^ 64;
        end
        return r[0];
    endfunction

    function automatic logic [63:0] rotw(input logic [63:0] v, input int n, input int w);
        logic [63:0] m;
        int k;
        m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        k = n % w;
        if (k == 0) return v & m;
        return ((v << k) | (v >> (w - k))) & m;
    endfunction

    // Rounds first..NR-1 of Keccak-f[25w]; state in the low 25w bits.
    function automatic logic [1599:0] ref_perm(input logic [1599:0] v, input int w, input int first);
        logic [63:0]   a [25];
        logic [63:0]   b [25];
        logic [63:0]   c [5];
        logic [63:0]   d [5];
        int            rot [25];
        logic [63:0]   m;
        logic [1599:0] res;
        int x, y, t2;
        m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        rot[0] = 0;
        x = 1; y = 0;
        for (int t = 0; t < 24; t++) begin
            rot[x + 5*y] = ((t + 1) * (t + 2) / 2) % w;
            t2 = y; y = (2*x + 3*y) % 5; x = t2;
        end
        for (int i = 0; i < 25; i++) a[i] = 64'(v >> (25*w - w*(i+1))) & m;
        for (int ir = first; ir < nr_of(w); ir++) begin
            for (int xx = 0; xx < 5; xx++)
                c[xx] = a[xx] ^ a[xx+5] ^ a[xx+10] ^ a[xx+15] ^ a[xx+20];
            for (int xx = 0; xx < 5; xx++)
                d[xx] = c[(xx+4)%5] ^ rotw(c[(xx+1)%5], 1, w);
            for (int i = 0; i < 25; i++) a[i] = a[i] ^ d[i%5];
            // pi as A'[x,y] = A[(x+3y)%5, x], with rho applied to the source lane
            for (int xx = 0; xx < 5; xx++)
                for (int yy = 0; yy < 5; yy++)
                    b[xx + 5*yy] = rotw(a[(xx+3*yy)%5 + 5*xx], rot[(xx+3*yy)%5 + 5*xx], w);
            for (int xx = 0; xx < 5; xx++)
                for (int yy = 0; yy < 5; yy++)
                    a[xx+5*yy] = b[xx+5*yy] ^ (~b[(xx+1)%5 + 5*yy] & b[(xx+2)%5 + 5*yy] & m);
            for (int j = 0; j < 7; j++)
                if (lfsr_rc(j + 7*ir)) a[0] = a[0] ^ ((64'd1 << ((1 << j) - 1)) & m);
        end
        res = '0;
        for (int i = 0; i < 25; i++) res = res | (1600'(a[i]) << (25*w - w*(i+1)));
        return res;
    endfunction

    function automatic logic [1599:0] rand_state(input int w);
        logic [1599:0] v;
        for (int i = 0; i < 50; i++) v[32*i +: 32] = $urandom;
        return v & ((1600'd1 << (25*w)) - 1600'd1);
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string name, input logic [1599:0] act, input logic [1599:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            for (int i = 0; i < 25; i++)
                if (act[1599-64*i -: 64] !== exp[1599-64*i -: 64]) begin
                    $display("FAIL %s: word %0d got %h expected %h", name, i,
                             act[1599-64*i -: 64], exp[1599-64*i -: 64]);
                    break;
                end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [1599:0] din);
        int guard;
        guard = 0;
        while (!in_ready && guard < 200) begin tick(); guard++; end
        if (guard >= 200) chk("accept_ready_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_data  = din;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int first, output int lat, output logic [1599:0] dout);
        bit ok;
        lat = 0;
        ok  = 1'b1;
        while (!out_valid && lat < 100) begin
            if (round_idx !== 5'(first + lat) || busy !== 1'b1) ok = 1'b0;
            tick();
            lat++;
        end
        chk("run_ridx_busy", 64'(ok), 64'd1);
        chk("done_ridx", 64'(round_idx), 64'd24);
        chk("done_busy", 64'(busy), 64'd0);
        dout = out_data;
    endtask

    typedef struct {
        logic [1599:0] din;
        logic [63:0]   lane0;
        int            lat;
    } vec_t;
    vec_t vecs [2];

    initial begin
        logic [1599:0] din, dout, held, exp;
        int            lat, guard, w;
        bit            ok, rdy_ok;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        s_ivld = '0; s_ordy = '1; s_din = '0;
`ifdef KECCAK_NROUNDS_PORT_EN
        in_rounds = 5'd0; sub_rounds = 5'd0;
`endif
        repeat (3) tick();
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_round_idx", 64'(round_idx), 64'd0);
        chk_state("rst_out_data", out_data, '0);
        rst_n = 1'b1;
        tick();

        // Known-answer table: zero state, then its own image fed back.
        vecs[0] = '{din: '0, lane0: 64'hF1258F7940E1DDE7, lat: 24};
        vecs[1] = '{din: ref_perm('0, 64, 0), lane0: 64'h2D5C954DF96ECB3C, lat: 24};
        for (int i = 0; i < 2; i++) begin
            accept(vecs[i].din);
            wait_done(0, lat, dout);
            chk("kat_latency", 64'(lat), 64'(vecs[i].lat));
            chk("kat_lane00", dout[1599 -: 64], vecs[i].lane0);
            chk_state("kat_state", dout, ref_perm(vecs[i].din, 64, 0));
            tick();
        end

        // Backpressure in DONE: output held, in_valid ignored, then overlapped accept.
        out_ready = 1'b0;
        din = rand_state(64);
        accept(din);
        wait_done(0, lat, held);
        ok = 1'b1; rdy_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = rand_state(64);
            #1;
            if (in_ready !== 1'b0) rdy_ok = 1'b0;
            tick();
            if (out_data !== held || out_valid !== 1'b1 || busy !== 1'b0) ok = 1'b0;
        end
        chk("stall_hold", 64'(ok), 64'd1);
        chk("stall_in_ready_low", 64'(rdy_ok), 64'd1);
        chk_state("stall_result", held, ref_perm(din, 64, 0));
        din = rand_state(64);
        in_data = din;
        out_ready = 1'b1;
        #1;
        chk("overlap_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("overlap_busy", 64'(busy), 64'd1);
        chk("overlap_out_valid", 64'(out_valid), 64'd0);
        wait_done(0, lat, dout);
        chk("overlap_latency", 64'(lat), 64'd24);
        chk_state("overlap_state", dout, ref_perm(din, 64, 0));
        tick();

        // Random states with random output stalls.
        for (int k = 0; k < 12; k++) begin
            din = rand_state(64);
            exp = ref_perm(din, 64, 0);
            out_ready = 1'($urandom_range(0, 1));
            accept(din);
            wait_done(0, lat, dout);
            chk("rand_latency", 64'(lat), 64'd24);
            chk_state("rand_state", dout, exp);
            if (!out_ready) begin
                repeat ($urandom_range(1, 3)) tick();
                chk_state("rand_stall_hold", out_data, exp);
                out_ready = 1'b1;
            end
            tick();
        end

        // Reset pulsed mid-RUN at round 10.
        accept(rand_state(64));
        guard = 0;
        while (round_idx != 5'd10 && guard < 50) begin tick(); guard++; end
        chk("midrst_reach_r10", 64'(round_idx), 64'd10);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready",  64'(in_ready),  64'd1);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_busy",      64'(busy),      64'd0);
        chk("midrst_round_idx", 64'(round_idx), 64'd0);
        chk_state("midrst_out_data", out_data, '0);
        tick();
        rst_n = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid !== 1'b0 || busy !== 1'b0) ok = 1'b0;
        end
        chk("midrst_no_output", 64'(ok), 64'd1);

        // Every lane width / unroll factor against the model.
        for (int g = 0; g < 4; g++) begin
            w = 8 << g;
            for (int k = 0; k < ((g == 3) ? 20 : 100); k++) begin
                din = rand_state(w);
                guard = 0;
                while (!s_irdy[g] && guard < 50) begin tick(); guard++; end
                s_ivld[g] = 1'b1;
                s_din[g]  = din;
                tick();
                s_ivld[g] = 1'b0;
                lat = 0;
                while (!s_ovld[g] && lat < 100) begin tick(); lat++; end
                chk("sub_latency", 64'(lat), 64'(nr_of(w) / rpc_of(g)));
                chk("sub_done_ridx", 64'(s_ridx[g]), 64'(nr_of(w)));
                chk_state("sub_state", s_dout[g], ref_perm(din, w, 0));
                tick();
            end
        end

`ifdef KECCAK_NROUNDS_PORT_EN
        // Reduced round count on the main engine: last 12 rounds.
        din = rand_state(64);
        in_rounds = 5'd12;
        accept(din);
        wait_done(12, lat, dout);
        chk("nr12_latency", 64'(lat), 64'd12);
        chk_state("nr12_state", dout, ref_perm(din, 64, 12));
        tick();
        // Zero request falls back to the full count.
        din = rand_state(64);
        in_rounds = 5'd0;
        accept(din);
        wait_done(0, lat, dout);
        chk("nr0_latency", 64'(lat), 64'd24);
        chk_state("nr0_state", dout, ref_perm(din, 64, 0));
        tick();
        // 16-bit lanes, R=2: 7 is not a multiple of 2 -> full 20 rounds; 4 -> last 4.
        for (int i = 0; i < 2; i++) begin
            din = rand_state(16);
            sub_rounds = (i == 0) ? 5'd7 : 5'd4;
            s_ivld[1] = 1'b1;
            s_din[1]  = din;
            tick();
            s_ivld[1] = 1'b0;
            lat = 0;
            while (!s_ovld[1] && lat < 100) begin tick(); lat++; end
            chk("sub_nr_latency", 64'(lat), (i == 0) ? 64'd10 : 64'd2);
            chk_state("sub_nr_state", s_dout[1], ref_perm(din, 16, (i == 0) ? 0 : 16));
            tick();
        end
        sub_rounds = 5'd0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
